seq_det_prog: RTL and testbench

Parametrised, run-time programmable serial pattern detector for the `basics/fsm` family. It generalises the fixed 1011 Moore detector to any pattern of 1..MAX_LEN bits. It adds overlap/non-overlap mode, an input-valid qualifier for stalled streams, and a saturating match counter. With its reset configuration it replaces the fixed detector directly: `RST_PATTERN`=1011, `RST_LEN`=4, overlap on.

---
 rtl/seq_det_prog.sv | 98 +++++++++
 tb/tb_seq_det_prog.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Run-time programmable serial pattern detector with overlap control, input
// qualifier, saturating match counter and illegal-config flag.
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1011),
    parameter int                 RST_LEN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_in,
    input  logic                         in_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         overlap,
    output logic                         det,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cfg_err
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [LW-1:0]      len_q, len_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_inc;
    logic               match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            pat_q  <= RST_PATTERN;
            fill_q <= '0;
            len_q  <= LW'(RST_LEN);
            det_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            len_q  <= len_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Only the low len bits of the post-shift history take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
    end

    always_comb begin
        hist_d   = hist_q;
        pat_d    = pat_q;
        fill_d   = fill_q;
        len_d    = len_q;
        det_d    = 1'b0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shifted  = {hist_q[MAX_LEN-2:0], data_in};
        fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        match    = !err_q && (fill_inc >= len_q) && (((shifted ^ pat_q) & mask) == '0);

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            fill_d = '0;
            cnt_d  = '0;
            err_d  = (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
        end else if (in_valid) begin
            hist_d = shifted;
            det_d  = match;
            // Non-overlap mode forgets the history so the next match needs len fresh bits.
            fill_d = (match && !overlap) ? '0 : fill_inc;
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign det       = det_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Randomised and directed scoreboard bench for seq_det_prog, checked against a
// bit-queue reference model of the detector.
module tb_seq_det_prog;

    typedef struct packed {
        logic       det;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       overlap = 1'b1;
    logic       det;
    logic [2:0] match_cnt;
    logic       cfg_err;

    int total = 0;
    int bad = 0;
    int detSeen = 0;

    exp_t expQ[$];

    // Reference model: bits accepted since the last restart, plus active config.
    bit       mq[$];
    bit [7:0] mPat;
    int       mLen;
    bit       mErr;
    int       mCnt;
    bit       mDet;

    seq_det_prog #(
        .MAX_LEN(8),
        .CNT_W(3),
        .RST_PATTERN(8'b0000_1011),
        .RST_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .in_valid(in_valid),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .overlap(overlap),
        .det(det),
        .match_cnt(match_cnt),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPat = 8'b0000_1011;
        mLen = 4;
        mErr = 1'b0;
        mCnt = 0;
        mDet = 1'b0;
    endtask

    // Drive one clock's worth of inputs and queue what the DUT must show after the edge.
    task automatic applyStimulus(input bit v, input bit d, input bit load,
                                 input bit [7:0] p, input bit [3:0] l, input bit ov);
        bit hit;
        exp_t e;
        @(negedge clk);
        in_valid    = v;
        data_in     = d;
        cfg_load    = load;
        cfg_pattern = p;
        cfg_len     = l;
        overlap     = ov;
        if (load) begin
            mPat = p;
            mLen = l;
            mq.delete();
            mCnt = 0;
            mDet = 1'b0;
            mErr = (l == 0) || (l > 8);
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() > 8) void'(mq.pop_front());
            hit = !mErr && (mq.size() >= mLen);
            if (hit) begin
                for (int i = 0; i < mLen; i++) begin
                    if (mq[mq.size() - 1 - i] != mPat[i]) hit = 1'b0;
                end
            end
            mDet = hit;
            if (hit && mCnt != 7) mCnt++;
            if (hit && !ov) mq.delete();
        end else begin
            mDet = 1'b0;
        end
        e.det = mDet;
        e.cnt = 3'(mCnt);
        e.err = mErr;
        expQ.push_back(e);
    endtask

    task automatic drain();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, overlap);
        @(posedge clk);
        #2;
        checkOutput("queue_drained", 8'(expQ.size()), 8'd0);
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic doReset();
        in_valid = 1'b0;
        cfg_load = 1'b0;
        rst = 1'b0;
        expQ.delete();
        modelReset();
        #1;
        checkOutput("reset_det", {7'd0, det}, 8'd0);
        checkOutput("reset_cnt", {5'd0, match_cnt}, 8'd0);
        checkOutput("reset_err", {7'd0, cfg_err}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic sendStream(input logic [31:0] bits, input int n, input bit ov);
        logic [31:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, b[i], 1'b0, 8'h00, 4'd0, ov);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && expQ.size() > 0) begin
                e = expQ.pop_front();
                if (det === 1'b1) detSeen++;
                checkOutput("det", {7'd0, det}, {7'd0, e.det});
                checkOutput("match_cnt", {5'd0, match_cnt}, {5'd0, e.cnt});
                checkOutput("cfg_err", {7'd0, cfg_err}, {7'd0, e.err});
            end
        end
    end

    initial begin : stimulus
        bit [7:0] p;
        bit [3:0] l;
        modelReset();
        #2;
        doReset();

        $display("[TB] reset config, overlap on");
        detSeen = 0;
        sendStream(32'b00100101101100101101011, 23, 1'b1);
        drain();
        checkOutput("overlap_pulses", 8'(detSeen), 8'd4);
        checkOutput("overlap_count", {5'd0, match_cnt}, 8'd4);

        $display("[TB] reset config, overlap off");
        doReset();
        detSeen = 0;
        sendStream(32'b00100101101100101101011, 23, 1'b0);
        drain();
        checkOutput("nonoverlap_pulses", 8'(detSeen), 8'd3);
        checkOutput("nonoverlap_count", {5'd0, match_cnt}, 8'd3);

        $display("[TB] 8-bit pattern across stalls");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'b1110_0101, 4'd8, 1'b1);
        detSeen = 0;
        begin
            logic [15:0] s;
            s = 16'b1110010111100101;
            for (int i = 15; i >= 0; i--) begin
                applyStimulus(1'b1, s[i], 1'b0, 8'h00, 4'd0, 1'b1);
                applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
            end
        end
        drain();
        checkOutput("stall_pulses", 8'(detSeen), 8'd2);

        $display("[TB] illegal lengths");
        detSeen = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1);
        sendStream(32'hFFFF_0000, 32, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h0B, 4'd9, 1'b1);
        sendStream(32'b1011_1011_1011_0110_1011_1111_0000_1011, 32, 1'b1);
        drain();
        checkOutput("illegal_err", {7'd0, cfg_err}, 8'd1);
        checkOutput("illegal_pulses", 8'(detSeen), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1);
        drain();
        checkOutput("legal_err", {7'd0, cfg_err}, 8'd0);
        checkOutput("legal_count", {5'd0, match_cnt}, 8'd0);

        $display("[TB] saturation with single-bit pattern");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1);
        detSeen = 0;
        sendStream(32'h3FF, 10, 1'b1);
        drain();
        checkOutput("sat_pulses", 8'(detSeen), 8'd10);
        checkOutput("sat_count", {5'd0, match_cnt}, 8'd7);

        $display("[TB] reset mid-pattern");
        doReset();
        sendStream(32'b101, 3, 1'b1);
        @(posedge clk);
        #2;
        doReset();
        detSeen = 0;
        sendStream(32'b1, 1, 1'b1);
        drain();
        checkOutput("midreset_nodet", 8'(detSeen), 8'd0);
        sendStream(32'b1011, 4, 1'b1);
        drain();
        checkOutput("midreset_det", 8'(detSeen), 8'd1);

        $display("[TB] randomised traffic");
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                p = 8'($urandom);
                if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                else l = 4'($urandom_range(1, 4));
                applyStimulus(1'b0, 1'b0, 1'b1, p, l, 1'($urandom));
            end else begin
                applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 8'h00, 4'd0,
                              1'($urandom_range(0, 3) != 0));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
